// File: rtl/pixel_sched_pkg.sv
// Shared types and sizing helpers for the pixel scheduler.
package pixel_sched_pkg;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FCLR = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_e;

    // Window length in cycles for a given weight magnitude width.
    function automatic int window_len(input int width);
        return (32'sd1 << (width + 32'sd1)) + 32'sd2;
    endfunction

    // Bits needed to hold a window position 0..window_len-1.
    function automatic int cnt_width(input int width);
        return $clog2(window_len(width));
    endfunction

    // Bits needed for a pixel index, never less than one.
    function automatic int idx_width(input int height);
        return (height > 32'sd1) ? $clog2(height) : 32'sd1;
    endfunction

endpackage

// File: rtl/pixel_scheduler_window_counter.sv
// Window position counter: wraps at the end of each window, can cut a
// window short to a single clear cycle, and decodes the clear and
// accumulate strobes for the stochastic datapath.
module window_counter
    import pixel_sched_pkg::*;
#(
    parameter int WIN_LEN = 514,
    parameter int CW      = 10,
    parameter int SETTLE  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_i,
    input  logic          skip_i,
    input  logic          clear_i,
    output logic [CW-1:0] cnt_o,
    output logic          window_end_o,
    output logic          clr_n_o,
    output logic          acc_en_o
);

    localparam logic [CW-1:0] LAST_POS   = CW'(WIN_LEN - 1);
    localparam logic [CW-1:0] SETTLE_POS = CW'(SETTLE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          window_end_s;

    // Next window position and end-of-window detection.
    always_comb begin
        cnt_d        = cnt_q;
        window_end_s = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            if (skip_i || (cnt_q == LAST_POS)) begin
                cnt_d        = '0;
                window_end_s = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Window position register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign window_end_o = window_end_s;
    assign clr_n_o      = run_i && (cnt_q != '0);
    assign acc_en_o     = run_i && (cnt_q > SETTLE_POS);

endmodule

// File: rtl/pixel_scheduler.sv
// Frame sequencer for the time-multiplexed stochastic neuron datapath.
// Latches a pixel vector and weight signs on start, then walks every
// pixel through one window, driving divider polarity and clear/accumulate
// strobes. Optional build macro PIXEL_SKIP_EN shortens the window of a
// zero pixel to a single clear cycle.
module pixel_scheduler
    import pixel_sched_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 7,
    parameter int SETTLE = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [HEIGHT-1:0]                pixels,
    input  logic [HEIGHT-1:0]                weight_sign,
    output logic                             busy,
    output logic                             done,
    output logic                             frame_clr,
    output logic                             circuit_clr_n,
    output logic                             accumulate_en,
    output logic [idx_width(HEIGHT)-1:0]     pixel_idx,
    output logic                             polarity,
    output logic                             pixel_bit,
    output logic [cnt_width(WIDTH)-1:0]      cnt
);

    localparam int L  = window_len(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam int IW = idx_width(HEIGHT);
    localparam logic [IW-1:0] LAST_IDX = IW'(HEIGHT - 1);

    sched_state_e    state_q, state_d;
    logic [IW-1:0]   pixel_idx_q, pixel_idx_d;
    logic [HEIGHT-1:0] pixels_q, pixels_d;
    logic [HEIGHT-1:0] weight_sign_q, weight_sign_d;

    logic            run_s;
    logic            skip_s;
    logic            window_end_s;
    logic [CW-1:0]   cnt_s;

    assign run_s = (state_q == RUN);

`ifdef PIXEL_SKIP_EN
    // A zero pixel contributes nothing, so only its clear cycle is spent.
    assign skip_s = run_s && (cnt_s == '0) && !pixels_q[pixel_idx_q];
`else
    assign skip_s = 1'b0;
`endif

    window_counter #(
        .WIN_LEN (L),
        .CW      (CW),
        .SETTLE  (SETTLE)
    ) u_window_counter (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run_s),
        .skip_i       (skip_s),
        .clear_i      (abort),
        .cnt_o        (cnt_s),
        .window_end_o (window_end_s),
        .clr_n_o      (circuit_clr_n),
        .acc_en_o     (accumulate_en)
    );

    // Frame sequencing, pixel stepping and input capture.
    always_comb begin
        state_d       = state_q;
        pixel_idx_d   = pixel_idx_q;
        pixels_d      = pixels_q;
        weight_sign_d = weight_sign_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = FCLR;
                    pixel_idx_d   = '0;
                    pixels_d      = pixels;
                    weight_sign_d = weight_sign;
                end else begin
                    state_d = IDLE;
                end
            end
            FCLR: begin
                if (abort) begin
                    state_d     = IDLE;
                    pixel_idx_d = '0;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d     = IDLE;
                    pixel_idx_d = '0;
                end else if (window_end_s) begin
                    if (pixel_idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        pixel_idx_d = pixel_idx_q + IW'(1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d     = IDLE;
                pixel_idx_d = '0;
            end
            default: begin
                state_d     = IDLE;
                pixel_idx_d = '0;
            end
        endcase
    end

    // State, pixel index and captured frame registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pixel_idx_q   <= '0;
            pixels_q      <= '0;
            weight_sign_q <= '0;
        end else begin
            state_q       <= state_d;
            pixel_idx_q   <= pixel_idx_d;
            pixels_q      <= pixels_d;
            weight_sign_q <= weight_sign_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign frame_clr = (state_q == FCLR);
    assign pixel_idx = pixel_idx_q;
    assign polarity  = ~weight_sign_q[pixel_idx_q];
    assign pixel_bit = run_s & pixels_q[pixel_idx_q];
    assign cnt       = cnt_s;

endmodule
